// File: rtl/pc_next_unit_if.sv
// Control and status bundle between the fetch/decode logic and the PC stage.
// The core (master) drives next-PC controls; the PC stage (slave) returns fetch state.
interface pc_next_unit_if #(
    parameter int COUNT_WIDTH = 32
);
    logic                   stall;
    logic                   branch_taken;
    logic [31:0]            branch_offset;
    logic                   jump;
    logic [25:0]            jump_index;
    logic                   jr;
    logic [31:0]            jr_target;
    logic                   halt;
    logic                   resume;

    logic [31:0]            pc;
    logic [31:0]            pc_plus4;
    logic                   fetch_valid;
    logic                   misalign_err;
    logic                   halted;
    logic [COUNT_WIDTH-1:0] adv_count;

    modport master (
        output stall, branch_taken, branch_offset, jump, jump_index,
               jr, jr_target, halt, resume,
        input  pc, pc_plus4, fetch_valid, misalign_err, halted, adv_count
    );

    modport slave (
        input  stall, branch_taken, branch_offset, jump, jump_index,
               jr, jr_target, halt, resume,
        output pc, pc_plus4, fetch_valid, misalign_err, halted, adv_count
    );
endinterface

// File: rtl/pc_next_unit.sv
// Program counter register with next-PC selection (sequential, branch, jump, JR),
// stall/halt control, misaligned-JR trapping and a saturating advance counter.
module pc_next_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0180,
    parameter int          COUNT_WIDTH  = 32
) (
    input  logic clk,
    input  logic reset,
    pc_next_unit_if.slave bus
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [31:0]            pc_q;
    logic [31:0]            pc_next;
    logic [31:0]            pc_plus4;
    logic                   misalign_q;
    logic                   misalign_next;
    logic                   advance;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] count_next;

    assign pc_plus4 = pc_q + 32'd4;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= BOOT;
            pc_q       <= RESET_VECTOR;
            misalign_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state      <= state_next;
            pc_q       <= pc_next;
            misalign_q <= misalign_next;
            count_q    <= count_next;
        end
    end

    // halt outranks stall in RUN; a stalled cycle ignores every redirect input
    always_comb begin
        state_next    = state;
        pc_next       = pc_q;
        misalign_next = 1'b0;
        advance       = 1'b0;

        case (state)
            BOOT: begin
                state_next = RUN;
            end
            RUN: begin
                if (bus.halt) begin
                    state_next = HALTED;
                end else if (!bus.stall) begin
                    advance = 1'b1;
                    if (bus.jr) begin
                        if (bus.jr_target[1:0] == 2'b00) begin
                            pc_next = bus.jr_target;
                        end else begin
                            pc_next       = TRAP_VECTOR;
                            misalign_next = 1'b1;
                        end
                    end else if (bus.jump) begin
                        pc_next = {pc_plus4[31:28], bus.jump_index, 2'b00};
                    end else if (bus.branch_taken) begin
                        pc_next = pc_plus4 + bus.branch_offset;
                    end else begin
                        pc_next = pc_plus4;
                    end
                end
            end
            HALTED: begin
                if (bus.resume && !bus.halt) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    always_comb begin
        count_next = count_q;
        if (advance && (count_q != {COUNT_WIDTH{1'b1}})) begin
            count_next = count_q + 1'b1;
        end
    end

    assign bus.pc           = pc_q;
    assign bus.pc_plus4     = pc_plus4;
    assign bus.fetch_valid  = (state == RUN);
    assign bus.halted       = (state == HALTED);
    assign bus.misalign_err = misalign_q;
    assign bus.adv_count    = count_q;

endmodule
